// File: rtl/ap_ctrl_pkg.sv
// Shared types and default widths for the ap_ctrl initiator block.
package ap_ctrl_pkg;

    localparam int CNT_W_DEF     = 32;
    localparam int MAX_OUTST_DEF = 4;
    localparam int CMD_COUNT_W   = 16;
    localparam int CMD_DELAY_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO: first-word fall-through, any depth, push+pop allowed when full.
module ap_ts_fifo
    import ap_ctrl_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DEF,
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCW   = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == OCW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + OCW'(1);
            else if (do_pop && !do_push) count <= count - OCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ap_ctrl_initiator.sv
// Drives an HLS ap_ctrl_chain kernel for a commanded number of transactions,
// measuring per-transaction latency and total run time.
module ap_ctrl_initiator
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CMD_COUNT_W-1:0] cmd_count,
    input  logic [CMD_DELAY_W-1:0] cmd_cont_delay,
    output logic                   ap_start,
    input  logic                   ap_ready,
    input  logic                   ap_done,
    output logic                   ap_continue,
    output logic                   busy,
    output logic                   finish,
    output logic [CMD_COUNT_W-1:0] done_count,
    output logic [CNT_W-1:0]       last_latency,
    output logic [CNT_W-1:0]       max_latency,
    output logic [CNT_W-1:0]       total_cycles
);

    localparam int OCW = $clog2(MAX_OUTST + 1);

    // Handshakes: a transfer happens on any cycle where both sides of a pair
    // are high (cmd_valid/cmd_ready, ap_start/ap_ready, ap_done/ap_continue);
    // an offering side holds its signal until that cycle.

    state_t                 state;
    logic [CMD_COUNT_W-1:0] issued;
    logic [CMD_COUNT_W-1:0] target;
    logic [CMD_DELAY_W-1:0] delay;
    logic [CMD_DELAY_W-1:0] wait_ctr;
    logic [CNT_W-1:0]       cycle_ctr;
    logic [CNT_W-1:0]       ts_head;
    logic [CNT_W-1:0]       latency;
    logic [OCW-1:0]         outstanding;
    logic [OCW-1:0]         outst_n;
    logic [CMD_COUNT_W-1:0] issued_n;
    logic [CMD_COUNT_W-1:0] done_n;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   complete;

    assign accept      = ap_start && ap_ready && !fifo_full;
    assign ap_continue = ap_done && !fifo_empty && (wait_ctr == delay);
    assign complete    = ap_continue;
    assign issued_n    = issued + CMD_COUNT_W'(accept);
    assign done_n      = done_count + CMD_COUNT_W'(complete);
    assign outst_n     = outstanding + OCW'(accept) - OCW'(complete);
    // Modulo subtraction keeps latency correct across a cycle_ctr wrap.
    assign latency     = cycle_ctr - ts_head + CNT_W'(1);

    ap_ts_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (CNT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (cycle_ctr),
        .pop   (complete),
        .dout  (ts_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b1;
            ap_start     <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
            issued       <= '0;
            target       <= '0;
            delay        <= '0;
            wait_ctr     <= '0;
            cycle_ctr    <= '0;
            done_count   <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            total_cycles <= '0;
        end else begin
            cycle_ctr <= cycle_ctr + CNT_W'(1);
            issued    <= issued_n;

            if (ap_done && !fifo_empty && !complete) wait_ctr <= wait_ctr + CMD_DELAY_W'(1);
            else                                     wait_ctr <= '0;

            if (complete) begin
                done_count   <= done_n;
                last_latency <= latency;
                if (latency > max_latency) max_latency <= latency;
            end

            if ((state == ST_RUN || state == ST_DRAIN) && total_cycles != '1)
                total_cycles <= total_cycles + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target       <= cmd_count;
                        delay        <= cmd_cont_delay;
                        issued       <= '0;
                        done_count   <= '0;
                        last_latency <= '0;
                        max_latency  <= '0;
                        total_cycles <= '0;
                        cycle_ctr    <= '0;
                        cmd_ready    <= 1'b0;
                        if (cmd_count != '0) begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            ap_start <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    ap_start <= (issued_n < target) && (outst_n < OCW'(MAX_OUTST));
                    if (issued_n == target) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (done_n == target) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    finish    <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_ctrl_initiator.sv
// Directed bench for ap_ctrl_initiator using a narrow counter width to reach wrap/saturation quickly.
module tb_ap_ctrl_initiator;

    localparam int CW = 8;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [15:0]   cmd_count;
    logic [7:0]    cmd_cont_delay;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_continue;
    logic          busy;
    logic          finish;
    logic [15:0]   done_count;
    logic [CW-1:0] last_latency;
    logic [CW-1:0] max_latency;
    logic [CW-1:0] total_cycles;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int cmp_cnt = 0;
    int fin_cnt = 0;
    int a0, c0, f0;
    logic [31:0] exp_q[$];

    ap_ctrl_initiator #(.CNT_W(CW), .MAX_OUTST(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_count      (cmd_count),
        .cmd_cont_delay (cmd_cont_delay),
        .ap_start       (ap_start),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .ap_continue    (ap_continue),
        .busy           (busy),
        .finish         (finish),
        .done_count     (done_count),
        .last_latency   (last_latency),
        .max_latency    (max_latency),
        .total_cycles   (total_cycles)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // handshake event counters
    always @(posedge clock) begin
        if (ap_start && ap_ready)   acc_cnt <= acc_cnt + 1;
        if (ap_done && ap_continue) cmp_cnt <= cmp_cnt + 1;
        if (finish)                 fin_cnt <= fin_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // drivers
    task automatic start_run(input logic [15:0] cnt, input logic [7:0] dly);
        @(negedge clock);
        cmd_valid      = 1'b1;
        cmd_count      = cnt;
        cmd_cont_delay = dly;
        #1 check("rdy_pre", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        #1;
    endtask

    // One transaction: start accepted on the first cycle, done lat-1 cycles later.
    task automatic txn(input int lat);
        @(negedge clock);
        ap_ready = 1'b1;
        @(negedge clock);
        ap_ready = 1'b0;
        repeat (lat - 2) @(negedge clock);
        ap_done = 1'b1;
        #1 check("txn_cont", ap_continue, 1);
        @(negedge clock);
        ap_done = 1'b0;
        #1 check("txn_lat", last_latency, exp_q.pop_front());
    endtask

    initial begin
        int t;
        reset = 1'b1; cmd_valid = 1'b0; cmd_count = '0; cmd_cont_delay = '0;
        ap_ready = 1'b0; ap_done = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_start", ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_done", done_count, 0);
        check("rst_total", total_cycles, 0);

        // single transaction, delay 0, done 5 cycles after start
        ap_ready = 1'b1;
        a0 = acc_cnt; c0 = cmp_cnt; f0 = fin_cnt;
        start_run(1, 0);
        check("a_start", ap_start, 1);
        check("a_busy", busy, 1);
        check("a_ready", cmd_ready, 0);
        @(negedge clock); #1 check("a_start_off", ap_start, 0);
        repeat (3) @(negedge clock);
        @(negedge clock); ap_done = 1'b1;
        #1 check("a_cont", ap_continue, 1);
        @(negedge clock); ap_done = 1'b0;
        #1;
        check("a_finish", finish, 1);
        check("a_done", done_count, 1);
        check("a_last", last_latency, 6);
        check("a_max", max_latency, 6);
        check("a_total", total_cycles, 6);
        check("a_busy_off", busy, 0);
        @(negedge clock); #1;
        check("a_finish_off", finish, 0);
        check("a_ready_back", cmd_ready, 1);
        check("a_done_hold", done_count, 1);
        check("a_accepts", acc_cnt - a0, 1);
        check("a_compl", cmp_cnt - c0, 1);
        check("a_fin_pulses", fin_cnt - f0, 1);

        // eight transactions, outstanding limit 4
        a0 = acc_cnt; c0 = cmp_cnt; f0 = fin_cnt;
        start_run(8, 0);
        repeat (8) @(negedge clock);
        @(negedge clock); ap_done = 1'b1;
        #1;
        check("b_accepts4", acc_cnt - a0, 4);
        check("b_start_lim", ap_start, 0);
        check("b_busy", busy, 1);
        check("b_cont", ap_continue, 1);
        @(negedge clock); #1 check("b_start_resume", ap_start, 1);
        t = 0;
        while (!finish && t < 40) begin
            @(negedge clock); #1; t++;
        end
        check("b_finish", finish, 1);
        check("b_cont_empty", ap_continue, 0);
        check("b_done", done_count, 8);
        check("b_last", last_latency, 4);
        check("b_max", max_latency, 10);
        check("b_accepts8", acc_cnt - a0, 8);
        check("b_compl8", cmp_cnt - c0, 8);
        @(negedge clock); ap_done = 1'b0;
        #1 check("b_fin_pulses", fin_cnt - f0, 1);

        // continue delay 3 with ap_done held
        c0 = cmp_cnt;
        ap_ready = 1'b1;
        start_run(1, 3);
        @(negedge clock);
        @(negedge clock); ap_done = 1'b1;
        #1 check("c_cont_w0", ap_continue, 0);
        @(negedge clock); #1 check("c_cont_w1", ap_continue, 0);
        @(negedge clock); #1 check("c_cont_w2", ap_continue, 0);
        @(negedge clock); #1 check("c_cont_w3", ap_continue, 1);
        @(negedge clock); #1;
        check("c_cont_after", ap_continue, 0);
        check("c_finish", finish, 1);
        check("c_done", done_count, 1);
        check("c_last", last_latency, 6);
        @(negedge clock); ap_done = 1'b0;
        #1 check("c_compl", cmp_cnt - c0, 1);

        // zero-length run
        a0 = acc_cnt;
        start_run(0, 0);
        check("d_finish", finish, 1);
        check("d_start", ap_start, 0);
        check("d_busy", busy, 0);
        check("d_done", done_count, 0);
        check("d_max", max_latency, 0);
        @(negedge clock); #1;
        check("d_finish_off", finish, 0);
        check("d_ready", cmd_ready, 1);
        check("d_total", total_cycles, 0);
        check("d_accepts", acc_cnt - a0, 0);

        // reset mid-run with two outstanding
        a0 = acc_cnt; f0 = fin_cnt;
        ap_ready = 1'b1;
        start_run(5, 0);
        @(negedge clock);
        @(negedge clock); ap_ready = 1'b0;
        #1;
        check("e_outst2", acc_cnt - a0, 2);
        check("e_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0; ap_done = 1'b1;
        #1;
        check("e_start", ap_start, 0);
        check("e_busy_off", busy, 0);
        check("e_finish", finish, 0);
        check("e_ready", cmd_ready, 1);
        check("e_done", done_count, 0);
        check("e_total", total_cycles, 0);
        check("e_cont_empty", ap_continue, 0);
        @(negedge clock); ap_done = 1'b0;
        #1;
        check("e_no_finish", fin_cnt - f0, 0);
        check("e_done_ignored", done_count, 0);
        ap_ready = 1'b1;
        start_run(1, 0);
        @(negedge clock);
        @(negedge clock); ap_done = 1'b1;
        #1 check("e2_cont", ap_continue, 1);
        @(negedge clock); ap_done = 1'b0;
        #1;
        check("e2_finish", finish, 1);
        check("e2_done", done_count, 1);
        check("e2_last", last_latency, 3);

        // latencies 3, 9, 5
        ap_ready = 1'b0;
        exp_q = {32'd3, 32'd9, 32'd5};
        start_run(3, 0);
        txn(3);
        txn(9);
        txn(5);
        check("f_finish", finish, 1);
        check("f_max", max_latency, 9);
        check("f_last", last_latency, 5);
        check("f_done", done_count, 3);

        // timestamp wraps mid-transaction; run exceeds total_cycles range
        exp_q = {32'd12};
        start_run(1, 0);
        repeat (249) @(negedge clock);
        txn(12);
        check("g_finish", finish, 1);
        check("g_total_sat", total_cycles, 255);
        check("g_max", max_latency, 12);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
